// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB full-speed transmit encoder.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    DATA    = 3'd2,
    EOP_SE0 = 3'd3,
    EOP_J   = 3'd4
  } tx_state_e;

  // Line states as {dp, dm}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  localparam logic [7:0]  SYNC_BYTE    = 8'h80;
  localparam int unsigned EOP_SE0_BITS = 2;

  // NRZI: a 0 toggles J/K, a 1 holds the previous line state
  function automatic logic [1:0] nrzi_next(input logic [1:0] prev, input logic bit_val);
    if (bit_val) return prev;
    return (prev == LINE_K) ? LINE_J : LINE_K;
  endfunction

endpackage

// File: rtl/usb_tx_encoder_bit_timer.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 while enabled, ticks on the last count.
module tx_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic en,
  input  logic clr,
  output logic bit_tick
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Free-running bit counter, held at zero while cleared
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
    end
  end

  assign bit_tick = en && (cnt == CNT_MAX);

endmodule

// File: rtl/usb_tx_encoder.sv
// USB full-speed transmit line encoder: SYNC, LSB-first serialisation, bit stuffing, NRZI, EOP.
module usb_tx_encoder
  import usb_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned STUFF_LEN    = 6
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_err,
  output logic       tx_busy,
  output logic       tx_oe,
  output logic       d_plus_out,
  output logic       d_minus_out
);

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned STUFF_W = $clog2(STUFF_LEN + 1);
  localparam int unsigned EOP_W   = (EOP_SE0_BITS > 1) ? $clog2(EOP_SE0_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTE_W - 1);

  tx_state_e state, state_next;

  logic [BYTE_W-1:0]  shreg, shreg_n;
  logic [IDX_W-1:0]   bit_idx, bit_idx_n;
  logic [STUFF_W-1:0] stuff_cnt, stuff_cnt_n;
  logic [EOP_W-1:0]   eop_cnt, eop_cnt_n;
  logic [1:0]         line, line_n;
  logic               cur_last, cur_last_n;
  logic               bit_tick, timer_en, timer_clr;
  logic               stuff_due, nxt_bit;

  assign timer_en  = (state != IDLE);
  assign timer_clr = (state == IDLE);

  tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .en       (timer_en),
    .clr      (timer_clr),
    .bit_tick (bit_tick)
  );

  assign stuff_due = (stuff_cnt == STUFF_W'(STUFF_LEN));

  // Next bit to put on the line when the current bit time ends
  always_comb begin
    nxt_bit = 1'b0;
    if (state == IDLE) begin
      nxt_bit = SYNC_BYTE[0];
    end else if (stuff_due) begin
      nxt_bit = 1'b0;
    end else if (bit_idx != LAST_IDX) begin
      nxt_bit = shreg[bit_idx + IDX_W'(1)];
    end else begin
      nxt_bit = tx_data[0];
    end
  end

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; a pending stuff bit delays the byte boundary
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (tx_valid) state_next = SYNC;
      SYNC, DATA: begin
        if (bit_tick && !stuff_due && (bit_idx == LAST_IDX)) begin
          state_next = (!cur_last && tx_valid) ? DATA : EOP_SE0;
        end
      end
      EOP_SE0: if (bit_tick && (eop_cnt == EOP_W'(EOP_SE0_BITS - 1))) state_next = EOP_J;
      EOP_J:   if (bit_tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake pulses and datapath next values
  always_comb begin
    tx_ready    = 1'b0;
    tx_err      = 1'b0;
    shreg_n     = shreg;
    bit_idx_n   = bit_idx;
    stuff_cnt_n = stuff_cnt;
    eop_cnt_n   = eop_cnt;
    line_n      = line;
    cur_last_n  = cur_last;
    unique case (state)
      IDLE: begin
        if (tx_valid) begin
          shreg_n     = SYNC_BYTE;
          bit_idx_n   = '0;
          cur_last_n  = 1'b0;
          line_n      = nrzi_next(LINE_J, nxt_bit);
          stuff_cnt_n = nxt_bit ? STUFF_W'(1) : '0;
        end
      end
      SYNC, DATA: begin
        if (bit_tick) begin
          if (stuff_due) begin
            line_n      = nrzi_next(line, 1'b0);
            stuff_cnt_n = '0;
          end else if (bit_idx != LAST_IDX || (!cur_last && tx_valid)) begin
            if (bit_idx == LAST_IDX) begin
              tx_ready   = 1'b1;
              shreg_n    = tx_data;
              cur_last_n = tx_last;
              bit_idx_n  = '0;
            end else begin
              bit_idx_n  = bit_idx + IDX_W'(1);
            end
            line_n      = nrzi_next(line, nxt_bit);
            stuff_cnt_n = nxt_bit ? stuff_cnt + STUFF_W'(1) : '0;
          end else begin
            tx_err      = !cur_last;
            line_n      = LINE_SE0;
            eop_cnt_n   = '0;
            stuff_cnt_n = '0;
          end
        end
      end
      EOP_SE0: begin
        if (bit_tick) begin
          if (eop_cnt == EOP_W'(EOP_SE0_BITS - 1)) line_n = LINE_J;
          else                                     eop_cnt_n = eop_cnt + EOP_W'(1);
        end
      end
      EOP_J: ;
      default: line_n = LINE_J;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shreg     <= '0;
      bit_idx   <= '0;
      stuff_cnt <= '0;
      eop_cnt   <= '0;
      line      <= LINE_J;
      cur_last  <= 1'b0;
    end else begin
      shreg     <= shreg_n;
      bit_idx   <= bit_idx_n;
      stuff_cnt <= stuff_cnt_n;
      eop_cnt   <= eop_cnt_n;
      line      <= line_n;
      cur_last  <= cur_last_n;
    end
  end

  assign tx_busy     = (state != IDLE);
  assign tx_oe       = tx_busy;
  assign d_plus_out  = line[1];
  assign d_minus_out = line[0];

endmodule
